// File: rtl/serial_tx_port_if.sv
// Byte-write / status bundle between an output-bank register slot and the serial transmitter.
// master = CPU-side register slot and iomux, slave = transmitter.
interface serial_tx_port_if;
    logic       wr;
    logic [7:0] din;
    logic       clr_ovr;
    logic       tx;
    logic       busy;
    logic       full;
    logic [7:0] status;

    modport master (
        output wr, din, clr_ovr,
        input  tx, busy, full, status
    );

    modport slave (
        input  wr, din, clr_ovr,
        output tx, busy, full, status
    );
endinterface

// File: rtl/serial_tx_port.sv
// Asynchronous serial transmitter (8N1, LSB first) with a one-byte holding register.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_tx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             reset,
    serial_tx_port_if.slave  bus,
    output logic [2:0]       state_dbg
);

    // Handshake: wr is a one-cycle strobe with no ready return; full acts as not-ready.
    // A write is taken when full=0, or when the holding byte moves to the shifter in the
    // same cycle. Any other write while full is dropped and sets the sticky ovr flag.

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
`ifdef SERIAL_TX_PARITY_EN
    localparam logic PARITY_BUILD = 1'b1;
`else
    localparam logic PARITY_BUILD = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             ovr_q, ovr_d;
    logic             tx_q, tx_d;
    logic             baud_end;
    logic             xfer;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        full_d   = full_q;
        ovr_d    = ovr_q;
        tx_d     = tx_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d    = par_q;
`endif
        baud_end = (baud_q == BAUD_LAST);
        xfer     = full_q && ((state_q == IDLE) || (state_q == STOP && baud_end));

        if (baud_end) begin
            baud_d = '0;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (full_q) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    state_d = full_q ? START : IDLE;
                    tx_d    = !full_q;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase

        if (xfer) begin
            shift_d = hold_q;
            full_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^hold_q;
`endif
        end

        if (bus.wr && (!full_q || xfer)) begin
            hold_d = bus.din;
            full_d = 1'b1;
        end

        // A same-cycle overrun beats the clear.
        if (bus.wr && full_q && !xfer) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tx_q    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            tx_q    <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.tx     = tx_q;
    assign bus.busy   = (state_q != IDLE) | full_q;
    assign bus.full   = full_q;
    assign bus.status = {4'b0000, PARITY_BUILD, ovr_q, full_q, (state_q != IDLE) | full_q};
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_tx_port.sv
// Bench for serial_tx_port: a queue-of-line-levels reference model checked every cycle,
// directed scenarios with literal expectations, then randomized writes/clears/resets.
module tb_serial_tx_port;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 11;
  localparam bit PBIT = 1'b1;
`else
  localparam int FB = 10;
  localparam bit PBIT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  serial_tx_port_if bus ();

  serial_tx_port #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: exp_q holds the line level for each upcoming cycle of queued frames
  logic [0:0] exp_q[$];
  logic [7:0] hold_d;
  bit hold_v = 1'b0;
  bit m_ovr = 1'b0;
  bit m_tx = 1'b1;
  bit m_in_frame = 1'b0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit xfer;
    bit hold_old;
    if (reset === 1'b0) begin
      exp_q.delete();
      hold_v = 1'b0;
      m_ovr = 1'b0;
      m_tx = 1'b1;
      m_in_frame = 1'b0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      hold_old = hold_v;
      xfer = hold_old && (exp_q.size() == 0);
      if (xfer) begin
        repeat (CPB) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (CPB) exp_q.push_back(hold_d[b]);
        if (FB == 11) repeat (CPB) exp_q.push_back(^hold_d);
        repeat (CPB) exp_q.push_back(1'b1);
        hold_v = 1'b0;
      end
      if (bus.wr && (!hold_old || xfer)) begin
        hold_d = bus.din;
        hold_v = 1'b1;
      end
      if (bus.wr && hold_old && !xfer) m_ovr = 1'b1;
      else if (bus.clr_ovr) m_ovr = 1'b0;
      if (exp_q.size() > 0) begin
        m_tx = exp_q.pop_front();
        m_in_frame = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_in_frame = 1'b0;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", {7'b0, bus.tx}, {7'b0, m_tx});
      check("busy", {7'b0, bus.busy}, {7'b0, m_in_frame | hold_v});
      check("full", {7'b0, bus.full}, {7'b0, hold_v});
      check("status", bus.status, {4'b0000, PBIT, m_ovr, hold_v, m_in_frame | hold_v});
    end
  end

  // driver tasks
  task automatic cycle(input bit w, input logic [7:0] d, input bit c, input bit rs);
    @(negedge clk);
    bus.wr = w;
    bus.din = d;
    bus.clr_ovr = c;
    reset = rs;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_fall();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (bus.tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("start_bit_seen", {7'b0, seen}, 8'h01);
  endtask

  bit a5_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    bus.wr = 1'b0;
    bus.din = 8'h00;
    bus.clr_ovr = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", {7'b0, bus.tx}, 8'h01);
    check("reset_status", bus.status, {4'b0000, PBIT, 3'b000});
    idle(2);

    // single frame 8'hA5 with literal line levels
    cycle(1'b1, 8'hA5, 1'b0, 1'b1);
    wait_fall();
    for (int n = 0; n <= FB * CPB; n++) begin
      if (n > 0) idle(1);
      if (n % CPB == 1) begin
        if (n / CPB < 9) check("a5_bit", {7'b0, bus.tx}, {7'b0, a5_bits[n / CPB]});
        else if (n / CPB == FB - 1) check("a5_stop", {7'b0, bus.tx}, 8'h01);
      end
      if (n == FB * CPB - 1) check("a5_busy_end", {7'b0, bus.busy}, 8'h01);
      if (n == FB * CPB) check("a5_busy_drop", {7'b0, bus.busy}, 8'h00);
    end
    idle(3);

    // back-to-back 8'h01 then 8'h02
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    idle(1);
    cycle(1'b1, 8'h02, 1'b0, 1'b1);
    check("b2b_first_start", {7'b0, bus.tx}, 8'h00);
    for (int n = 1; n <= FB * CPB + 2 * CPB + 1; n++) begin
      idle(1);
      if (n == FB * CPB - 1) begin
        check("b2b_full_hold", {7'b0, bus.full}, 8'h01);
        check("b2b_stop", {7'b0, bus.tx}, 8'h01);
      end
      if (n == FB * CPB) begin
        check("b2b_second_start", {7'b0, bus.tx}, 8'h00);
        check("b2b_full_clear", {7'b0, bus.full}, 8'h00);
      end
      if (n == FB * CPB + CPB + 1) check("b2b_02_bit0", {7'b0, bus.tx}, 8'h00);
      if (n == FB * CPB + 2 * CPB + 1) check("b2b_02_bit1", {7'b0, bus.tx}, 8'h01);
    end
    idle(FB * CPB);
    check("b2b_no_ovr", {7'b0, bus.status[2]}, 8'h00);

    // overrun: third consecutive write dropped
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    idle(1);
    check("ovr_status", bus.status, {4'b0000, PBIT, 3'b111});
    idle(2 * FB * CPB + 10);
    check("ovr_sticky", bus.status, {4'b0000, PBIT, 3'b100});
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle(1);
    check("ovr_cleared", {7'b0, bus.status[2]}, 8'h00);
    cycle(1'b1, 8'h44, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b1, 1'b1);
    idle(1);
    check("ovr_set_wins", {7'b0, bus.status[2]}, 8'h01);
    idle(2 * FB * CPB + 10);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle(2);

    // write landing on the holding-to-shifter transfer edge
    cycle(1'b1, 8'hA1, 1'b0, 1'b1);
    wait_fall();
    idle(1);
    cycle(1'b1, 8'hB2, 1'b0, 1'b1);
    idle(FB * CPB - 4);
    cycle(1'b1, 8'h5A, 1'b0, 1'b1);
    idle(1);
    check("xfer_no_ovr", {7'b0, bus.status[2]}, 8'h00);
    check("xfer_full", {7'b0, bus.full}, 8'h01);
    check("xfer_next_start", {7'b0, bus.tx}, 8'h00);
    idle(2 * FB * CPB + 10);

    // reset during data bit 3
    cycle(1'b1, 8'hC3, 1'b0, 1'b1);
    wait_fall();
    idle(16);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("midreset_tx", {7'b0, bus.tx}, 8'h01);
    check("midreset_status", bus.status, {4'b0000, PBIT, 3'b000});
    cycle(1'b1, 8'h96, 1'b0, 1'b1);
    idle(FB * CPB + 10);

`ifdef SERIAL_TX_PARITY_EN
    // parity bit for 8'h07 (odd count of ones) then 8'h03 (even count)
    cycle(1'b1, 8'h07, 1'b0, 1'b1);
    wait_fall();
    for (int n = 1; n <= FB * CPB; n++) begin
      idle(1);
      if (n == 9 * CPB + 1) check("par_07", {7'b0, bus.tx}, 8'h01);
      if (n == FB * CPB - 1) check("par_busy_end", {7'b0, bus.busy}, 8'h01);
      if (n == FB * CPB) check("par_busy_drop", {7'b0, bus.busy}, 8'h00);
    end
    cycle(1'b1, 8'h03, 1'b0, 1'b1);
    wait_fall();
    for (int n = 1; n <= 9 * CPB + 1; n++) begin
      idle(1);
      if (n == 9 * CPB + 1) check("par_03", {7'b0, bus.tx}, 8'h00);
    end
    idle(FB * CPB);
`endif

    // randomized writes, clears and occasional resets
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 299) != 0);
    end
    idle(2 * FB * CPB + 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
